// File: rtl/tdp_bram_bist.sv
// March-style BIST for a true-dual-port BRAM: W0 writes P, R0W1 reads P on B while A writes ~P one
// address behind, R1 reads ~P on both ports in opposite directions, DRAIN checks the last read.
module tdp_bram_bist #(
  parameter int               ABITS = 8,
  parameter int               DBITS = 16,
  parameter int               DEPTH = 256,
  parameter logic [DBITS-1:0] SEED  = 16'hA5C3,
  parameter int               ECW   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [ABITS-1:0] a_a,
  output logic [DBITS-1:0] wd_a,
  output logic             we_a,
  input  logic [DBITS-1:0] rd_a,
  output logic [ABITS-1:0] a_b,
  output logic [DBITS-1:0] wd_b,
  output logic             we_b,
  input  logic [DBITS-1:0] rd_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ECW-1:0]   err_count,
  output logic [ABITS-1:0] fail_addr,
  output logic             fail_port
);

  localparam int          CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LAST  = CW'(DEPTH - 1);
  localparam logic [CW-1:0] FINAL = CW'(DEPTH);

  typedef enum logic [2:0] {IDLE, W0, R0W1, R1, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ECW-1:0]   errCnt_q, errCnt_d;
  logic             done_q, done_d, pass_q, pass_d;
  logic [ABITS-1:0] failAddr_q, failAddr_d;
  logic             failPort_q, failPort_d;
  logic             vA_q, vA_d, vB_q, vB_d;
  logic [ABITS-1:0] addrA_q, addrA_d, addrB_q, addrB_d;
  logic [DBITS-1:0] expA_q, expA_d, expB_q, expB_d;

  logic [ABITS-1:0] idx, idxPrev, idxRev;
  logic             misA, misB;
  logic [ECW:0]     errSum;

  function automatic logic [DBITS-1:0] pat(input logic [ABITS-1:0] x);
    return SEED ^ DBITS'(x);
  endfunction

  assign idx     = ABITS'(cnt_q);
  assign idxPrev = ABITS'(cnt_q - 1'b1);
  assign idxRev  = ABITS'(LAST - cnt_q);
  assign misA    = vA_q && (rd_a != expA_q);
  assign misB    = vB_q && (rd_b != expB_q);
  assign errSum  = {1'b0, errCnt_q} + (ECW+1)'(misA) + (ECW+1)'(misB);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    errCnt_d   = errSum[ECW] ? '1 : errSum[ECW-1:0];
    done_d     = done_q;
    pass_d     = pass_q;
    failAddr_d = failAddr_q;
    failPort_d = failPort_q;
    vA_d       = 1'b0;
    vB_d       = 1'b0;
    addrA_d    = '0;
    addrB_d    = '0;
    expA_d     = '0;
    expB_d     = '0;
    a_a        = '0;
    wd_a       = '0;
    we_a       = 1'b0;
    a_b        = '0;
    wd_b       = '0;
    we_b       = 1'b0;

    // Only the first mismatch is recorded; port A wins a same-cycle tie.
    if ((misA || misB) && errCnt_q == '0) begin
      failAddr_d = misA ? addrA_q : addrB_q;
      failPort_d = !misA;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = W0;
          cnt_d      = '0;
          errCnt_d   = '0;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          failAddr_d = '0;
          failPort_d = 1'b0;
        end
      end
      W0: begin
        we_a  = 1'b1;
        a_a   = idx;
        wd_a  = pat(idx);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = R0W1;
          cnt_d   = '0;
        end
      end
      R0W1: begin
        if (cnt_q != FINAL) begin
          a_b     = idx;
          wd_b    = pat(idx);
          vB_d    = 1'b1;
          addrB_d = idx;
          expB_d  = pat(idx);
        end
        if (cnt_q != '0) begin
          we_a = 1'b1;
          a_a  = idxPrev;
          wd_a = ~pat(idxPrev);
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == FINAL) begin
          state_d = R1;
          cnt_d   = '0;
        end
      end
      R1: begin
        a_a     = idx;
        a_b     = idxRev;
        wd_b    = pat(idxRev);
        vA_d    = 1'b1;
        vB_d    = 1'b1;
        addrA_d = idx;
        addrB_d = idxRev;
        expA_d  = ~pat(idx);
        expB_d  = ~pat(idxRev);
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
        pass_d  = (errCnt_d == '0);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      errCnt_q   <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      failAddr_q <= '0;
      failPort_q <= 1'b0;
      vA_q       <= 1'b0;
      vB_q       <= 1'b0;
      addrA_q    <= '0;
      addrB_q    <= '0;
      expA_q     <= '0;
      expB_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      errCnt_q   <= errCnt_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      failAddr_q <= failAddr_d;
      failPort_q <= failPort_d;
      vA_q       <= vA_d;
      vB_q       <= vB_d;
      addrA_q    <= addrA_d;
      addrB_q    <= addrB_d;
      expA_q     <= expA_d;
      expB_q     <= expB_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = errCnt_q;
  assign fail_addr = failAddr_q;
  assign fail_port = failPort_q;

endmodule
